// File: rtl/snowbro2_snd_pkg.sv
// Shared definitions for the Snow Bros 2 sound-bus bridge: bridge FSM
// states, decoded bus targets, YM2151 a0 meaning and counter widths.
package snowbro2_snd_pkg;

   localparam int CNT_W = 2;   // cen pulse / read-wait counter width
   localparam int TMO_W = 10;  // no-cen timeout counter width

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WSTROBE = 2'd1,
      ST_RDWAIT  = 2'd2,
      ST_ACK     = 2'd3
   } bus_state_t;

   typedef enum logic [1:0] {
      TGT_NONE = 2'd0,
      TGT_YM   = 2'd1,
      TGT_OKI  = 2'd2,
      TGT_BANK = 2'd3
   } target_t;

   // YM2151 a0: register-select cycle versus data cycle
   localparam logic YM_A0_REG  = 1'b0;
   localparam logic YM_A0_DATA = 1'b1;

   // Exactly one select must be high for a cycle to be accepted
   function automatic target_t decode_target(input logic ym_sel,
                                              input logic oki_sel,
                                              input logic bank_sel);
      target_t t;
      case ({ym_sel, oki_sel, bank_sel})
         3'b100:  t = TGT_YM;
         3'b010:  t = TGT_OKI;
         3'b001:  t = TGT_BANK;
         default: t = TGT_NONE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/snowbro2_cen_hold.sv
// Counts qualified clock-enable pulses against a limit and flags done when
// the limit-th pulse arrives, or when the engine has been busy for TIMEOUT
// cycles so a paused sound clock can never hang the CPU.
// Ports:
//   CLK, RESET_N   clock, async active-low reset
//   busy           counting window open; counters held at zero otherwise
//   count_en       pulses are counted only while this is high
//   cen            pulse input (already selected by the caller)
//   limit          number of pulses to span
//   done           combinational: exit this cycle
module snowbro2_cen_hold
   import snowbro2_snd_pkg::*;
#(
   parameter logic [TMO_W-1:0] TIMEOUT = 10'd1023
)(
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             busy,
   input  logic             count_en,
   input  logic             cen,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ONE = 2'd1;
   localparam logic [TMO_W-1:0] TMO_ONE = 10'd1;

   logic [CNT_W-1:0] cnt_r;
   logic [TMO_W-1:0] tmo_r;
   logic             pulse_hit_s;

   // Pulse and timeout counters, cleared whenever the window is closed
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_r <= {CNT_W{1'b0}};
         tmo_r <= {TMO_W{1'b0}};
      end else if (!busy) begin
         cnt_r <= {CNT_W{1'b0}};
         tmo_r <= {TMO_W{1'b0}};
      end else begin
         if (count_en && cen) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
         if (tmo_r != TIMEOUT) begin
            tmo_r <= tmo_r + TMO_ONE;
         end
      end
   end

   // The pulse arriving this cycle completes the span, so exit right on it
   always_comb begin
      pulse_hit_s = 1'b0;
      if (count_en && cen && ((cnt_r + CNT_ONE) == limit)) begin
         pulse_hit_s = 1'b1;
      end else begin
         pulse_hit_s = 1'b0;
      end
      done = busy && (pulse_hit_s || (tmo_r == TIMEOUT));
   end

endmodule

// File: rtl/snowbro2_sound_bus.sv
// 68000-side bridge for the Snow Bros 2 sound stage. Turns decoded CPU bus
// cycles into YM2151 / OKI6295 write strobes and read data, and holds the
// OKI ROM bank bit. Write strobes stay low until the target chip's cen has
// sampled them HOLD times; DTACK is withheld until the strobe is released.
// Ports:
//   CLK, RESET_N                 CPU clock, async active-low reset
//   YM2151_CEN, OKI_CEN          sound-chip clock enables
//   YM_SEL, OKI_SEL, BANK_SEL    decoder selects (exactly one per cycle)
//   CPU_A1, CPU_RNW, CPU_LDS_N   68k address bit 1, read/write, lower strobe
//   CPU_DIN / CPU_DOUT           68k data in / read data out
//   CPU_DTACK_N                  68k acknowledge, active low
//   YM2151_CS/WE/WR_CMD/DIN/DOUT YM2151 bus
//   OKI_WE/DIN/DOUT, OKI_BANK    OKI6295 bus and ROM bank
module snowbro2_sound_bus
   import snowbro2_snd_pkg::*;
#(
   parameter logic [CNT_W-1:0] YM_HOLD  = 2'd2,
   parameter logic [CNT_W-1:0] OKI_HOLD = 2'd1,
   parameter logic [CNT_W-1:0] RD_WAIT  = 2'd2,
   parameter logic [TMO_W-1:0] TIMEOUT  = 10'd1023
)(
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       YM2151_CEN,
   input  logic       OKI_CEN,
   input  logic       YM_SEL,
   input  logic       OKI_SEL,
   input  logic       BANK_SEL,
   input  logic       CPU_A1,
   input  logic       CPU_RNW,
   input  logic       CPU_LDS_N,
   input  logic [7:0] CPU_DIN,
   output logic [7:0] CPU_DOUT,
   output logic       CPU_DTACK_N,
   output logic       YM2151_CS,
   output logic       YM2151_WE,
   output logic       YM2151_WR_CMD,
   output logic [7:0] YM2151_DIN,
   input  logic [7:0] YM2151_DOUT,
   output logic       OKI_WE,
   output logic [7:0] OKI_DIN,
   input  logic [7:0] OKI_DOUT,
   output logic       OKI_BANK
);

   bus_state_t       state_r, state_next_s;
   target_t          tgt_r, start_tgt_s;
   logic             rnw_r, a1_r, lds_prev_r, start_s;
   logic [7:0]       din_r;
   logic             busy_s, count_en_s, hold_cen_s, hold_done_s;
   logic [CNT_W-1:0] hold_limit_s;
   logic             ym_cs_s, oki_strobe_s, dtack_n_s, bank_wr_s, rd_load_s;
   logic [7:0]       rd_data_s;
   logic [7:0]       dout_r, ym_din_r, oki_din_r;
   logic             dtack_n_r, ym_cs_r, ym_we_r, ym_wr_cmd_r, oki_we_r, oki_bank_r;

   // A cycle starts only from IDLE, on a registered LDS fall with one select
   assign start_tgt_s = decode_target(YM_SEL, OKI_SEL, BANK_SEL);
   assign start_s     = (state_r == ST_IDLE) && lds_prev_r && !CPU_LDS_N &&
                        (start_tgt_s != TGT_NONE);

   // FSM state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!start_s)                      state_next_s = ST_IDLE;
            else if (CPU_RNW)                  state_next_s = ST_RDWAIT;
            else if (start_tgt_s == TGT_BANK)  state_next_s = ST_ACK;
            else                               state_next_s = ST_WSTROBE;
         end
         ST_WSTROBE, ST_RDWAIT: begin
            if (hold_done_s) state_next_s = ST_ACK;
            else             state_next_s = state_r;
         end
         ST_ACK: begin
            if (CPU_LDS_N) state_next_s = ST_IDLE;
            else           state_next_s = ST_ACK;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs: strobe falls a cycle after entry, rises on the exit cycle
   always_comb begin
      ym_cs_s      = 1'b0;
      oki_strobe_s = 1'b0;
      dtack_n_s    = 1'b1;
      bank_wr_s    = 1'b0;
      rd_load_s    = 1'b0;
      case (state_r)
         ST_WSTROBE: begin
            if (state_next_s == ST_WSTROBE) begin
               ym_cs_s      = (tgt_r == TGT_YM);
               oki_strobe_s = (tgt_r == TGT_OKI);
            end else begin
               ym_cs_s      = 1'b0;
               oki_strobe_s = 1'b0;
            end
         end
         ST_RDWAIT: rd_load_s = (state_next_s == ST_ACK);
         ST_ACK: begin
            dtack_n_s = 1'b0;
            bank_wr_s = (tgt_r == TGT_BANK) && !rnw_r;
         end
         default: begin
            ym_cs_s = 1'b0;
         end
      endcase
   end

   // Select the cen, limit and count qualifier for the shared hold counter
   always_comb begin
      busy_s       = (state_r == ST_WSTROBE) || (state_r == ST_RDWAIT);
      hold_cen_s   = 1'b0;
      count_en_s   = 1'b0;
      hold_limit_s = RD_WAIT;
      case (state_r)
         ST_WSTROBE: begin
            if (tgt_r == TGT_YM) begin
               hold_cen_s   = YM2151_CEN;
               count_en_s   = !ym_we_r;     // only cens the chip sees with WE low
               hold_limit_s = YM_HOLD;
            end else begin
               hold_cen_s   = OKI_CEN;
               count_en_s   = !oki_we_r;
               hold_limit_s = OKI_HOLD;
            end
         end
         ST_RDWAIT: begin
            hold_cen_s   = 1'b1;            // read wait counts plain clock cycles
            count_en_s   = 1'b1;
            hold_limit_s = RD_WAIT;
         end
         default: hold_limit_s = RD_WAIT;
      endcase
   end

   // Read data mux
   always_comb begin
      case (tgt_r)
         TGT_YM:   rd_data_s = YM2151_DOUT;
         TGT_OKI:  rd_data_s = OKI_DOUT;
         TGT_BANK: rd_data_s = {7'b0000000, oki_bank_r};
         default:  rd_data_s = 8'h00;
      endcase
   end

   snowbro2_cen_hold #(.TIMEOUT(TIMEOUT)) u_cen_hold (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .busy     (busy_s),
      .count_en (count_en_s),
      .cen      (hold_cen_s),
      .limit    (hold_limit_s),
      .done     (hold_done_s)
   );

   // LDS edge history and capture of the cycle attributes at start
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lds_prev_r <= 1'b1;
         tgt_r      <= TGT_NONE;
         rnw_r      <= 1'b1;
         a1_r       <= 1'b0;
         din_r      <= 8'h00;
      end else begin
         lds_prev_r <= CPU_LDS_N;
         if (start_s) begin
            tgt_r <= start_tgt_s;
            rnw_r <= CPU_RNW;
            a1_r  <= CPU_A1;
            din_r <= CPU_DIN;
         end
      end
   end

   // Registered outputs toward the CPU and both sound chips
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         dout_r      <= 8'h00;
         dtack_n_r   <= 1'b1;
         ym_cs_r     <= 1'b0;
         ym_we_r     <= 1'b1;
         ym_wr_cmd_r <= YM_A0_REG;
         ym_din_r    <= 8'h00;
         oki_we_r    <= 1'b1;
         oki_din_r   <= 8'h00;
         oki_bank_r  <= 1'b0;
      end else begin
         dtack_n_r <= dtack_n_s;
         ym_cs_r   <= ym_cs_s;
         ym_we_r   <= !ym_cs_s;
         oki_we_r  <= !oki_strobe_s;
         if (ym_cs_s) begin
            ym_din_r    <= din_r;
            ym_wr_cmd_r <= a1_r ? YM_A0_DATA : YM_A0_REG;
         end
         if (oki_strobe_s) oki_din_r  <= din_r;
         if (bank_wr_s)    oki_bank_r <= din_r[0];
         if (rd_load_s)    dout_r     <= rd_data_s;
      end
   end

   assign CPU_DOUT      = dout_r;
   assign CPU_DTACK_N   = dtack_n_r;
   assign YM2151_CS     = ym_cs_r;
   assign YM2151_WE     = ym_we_r;
   assign YM2151_WR_CMD = ym_wr_cmd_r;
   assign YM2151_DIN    = ym_din_r;
   assign OKI_WE        = oki_we_r;
   assign OKI_DIN       = oki_din_r;
   assign OKI_BANK      = oki_bank_r;

endmodule

// File: tb/tb_snowbro2_sound_bus.sv
// Self-checking bench for snowbro2_sound_bus. Inputs are driven and outputs
// observed on the falling clock edge; expectations come from the bus rules
// (strobe timing from the cen schedule, read latency, bank value model).
module tb_snowbro2_sound_bus;

   localparam int YM_HOLD  = 2;
   localparam int OKI_HOLD = 1;
   localparam int RD_WAIT  = 2;
   localparam int TIMEOUT  = 1023;

   logic       clk, rst_n, ym_cen, oki_cen, ym_sel, oki_sel, bank_sel;
   logic       a1, rnw, lds_n;
   logic [7:0] din, ym_dout, oki_dout;
   logic [7:0] cpu_dout, ym_din, oki_din;
   logic       cpu_dtack_n, ym_cs, ym_we, ym_wr_cmd, oki_we, oki_bank;

   int  n_cmp = 0;
   int  n_err = 0;
   logic bank_m = 1'b0;   // model of the OKI bank bit

   snowbro2_sound_bus dut (
      .CLK(clk), .RESET_N(rst_n), .YM2151_CEN(ym_cen), .OKI_CEN(oki_cen),
      .YM_SEL(ym_sel), .OKI_SEL(oki_sel), .BANK_SEL(bank_sel),
      .CPU_A1(a1), .CPU_RNW(rnw), .CPU_LDS_N(lds_n), .CPU_DIN(din),
      .CPU_DOUT(cpu_dout), .CPU_DTACK_N(cpu_dtack_n),
      .YM2151_CS(ym_cs), .YM2151_WE(ym_we), .YM2151_WR_CMD(ym_wr_cmd),
      .YM2151_DIN(ym_din), .YM2151_DOUT(ym_dout),
      .OKI_WE(oki_we), .OKI_DIN(oki_din), .OKI_DOUT(oki_dout), .OKI_BANK(oki_bank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_idle();
      ym_sel = 1'b0; oki_sel = 1'b0; bank_sel = 1'b0;
      lds_n = 1'b1; rnw = 1'b1; a1 = 1'b0; din = 8'h00;
   endtask

   // Release LDS and expect DTACK to return high within a few cycles
   task automatic release_bus(input string tag);
      bit seen;
      bus_idle();
      ym_cen = 1'b0; oki_cen = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         if (cpu_dtack_n) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b1) begin
         n_err++;
         $display("FAIL %s_dtack_release: DTACK_N stayed %b, want 1 after LDS high", tag, cpu_dtack_n);
      end
   endtask

   // YM or OKI write with a periodic cen; optionally drop LDS early at obs rel_at
   task automatic write_txn(input bit is_oki, input logic a1_v, input logic [7:0] d,
                            input int period, input int phase, input int rel_at, input string tag);
      int hold, k, hits, we_fall, we_rise, dt_fall, cens_low;
      logic we_o, we_prev, cen_now, cs_fall, cs_rise, cmd_fall;
      logic [7:0] din_fall;
      hold = is_oki ? OKI_HOLD : YM_HOLD;
      hits = 0; k = -1;
      for (int t = 2; t < 100; t++) begin
         if (k < 0 && (t % period) == phase) begin
            hits++;
            if (hits == hold) k = t;
         end
      end
      @(negedge clk);
      ym_sel = !is_oki; oki_sel = is_oki; bank_sel = 1'b0;
      rnw = 1'b0; a1 = a1_v; din = d; lds_n = 1'b0;
      we_fall = -1; we_rise = -1; dt_fall = -1; cens_low = 0; we_prev = 1'b1;
      cs_fall = 1'b0; cs_rise = 1'b1; cmd_fall = 1'b0; din_fall = 8'h00;
      for (int j = 0; j < 100 && dt_fall < 0; j++) begin
         cen_now = ((j % period) == phase);
         if (is_oki) begin oki_cen = cen_now; ym_cen = 1'($urandom_range(0, 1)); end
         else        begin ym_cen = cen_now; oki_cen = 1'($urandom_range(0, 1)); end
         @(negedge clk);
         we_o = is_oki ? oki_we : ym_we;
         if (cen_now && !we_prev) cens_low++;
         if (!we_o && we_fall < 0) begin
            we_fall = j; cs_fall = ym_cs; cmd_fall = ym_wr_cmd;
            din_fall = is_oki ? oki_din : ym_din;
         end
         if (we_o && we_fall >= 0 && we_rise < 0) begin we_rise = j; cs_rise = ym_cs; end
         if (!cpu_dtack_n && dt_fall < 0) dt_fall = j;
         we_prev = we_o;
         if (j == rel_at) begin lds_n = 1'b1; ym_sel = 1'b0; oki_sel = 1'b0; end
      end
      n_cmp++; if (we_fall != 1) begin n_err++; $display("FAIL %s_we_fall: strobe low at cycle %0d, want 1", tag, we_fall); end
      n_cmp++; if (cens_low != hold) begin n_err++; $display("FAIL %s_cen_span: strobe spanned %0d cens, want %0d", tag, cens_low, hold); end
      n_cmp++; if (we_rise != k) begin n_err++; $display("FAIL %s_we_rise: strobe high at cycle %0d, want %0d", tag, we_rise, k); end
      n_cmp++; if (dt_fall != k + 1) begin n_err++; $display("FAIL %s_dtack: DTACK low at cycle %0d, want %0d", tag, dt_fall, k + 1); end
      n_cmp++; if (din_fall !== d) begin n_err++; $display("FAIL %s_data: chip din %h, want %h", tag, din_fall, d); end
      n_cmp++; if (cs_fall !== !is_oki) begin n_err++; $display("FAIL %s_cs: YM CS %b during strobe, want %b", tag, cs_fall, !is_oki); end
      n_cmp++; if (cs_rise !== 1'b0) begin n_err++; $display("FAIL %s_cs_release: YM CS %b after strobe, want 0", tag, cs_rise); end
      if (!is_oki) begin
         n_cmp++; if (cmd_fall !== a1_v) begin n_err++; $display("FAIL %s_wr_cmd: a0 %b, want %b", tag, cmd_fall, a1_v); end
      end
      if (rel_at >= 0) begin
         ym_cen = 1'b0; oki_cen = 1'b0;
         @(negedge clk);
         n_cmp++; if (cpu_dtack_n !== 1'b1) begin n_err++; $display("FAIL %s_abort_pulse: DTACK_N %b one cycle after ack, want 1", tag, cpu_dtack_n); end
      end else begin
         release_bus(tag);
      end
   endtask

   // Read from tgt (0 YM, 1 OKI, 2 bank); chips return v and ~v
   task automatic read_txn(input int tgt, input logic [7:0] v, input string tag);
      int dt_fall;
      logic [7:0] exp_v, got;
      ym_dout = v; oki_dout = ~v;
      exp_v = (tgt == 0) ? v : (tgt == 1) ? ~v : {7'b0000000, bank_m};
      @(negedge clk);
      ym_sel = (tgt == 0); oki_sel = (tgt == 1); bank_sel = (tgt == 2);
      rnw = 1'b1; lds_n = 1'b0;
      dt_fall = -1; got = 8'hxx;
      for (int j = 0; j < 20 && dt_fall < 0; j++) begin
         @(negedge clk);
         if (!cpu_dtack_n) begin dt_fall = j; got = cpu_dout; end
      end
      n_cmp++; if (dt_fall != RD_WAIT + 1) begin n_err++; $display("FAIL %s_latency: DTACK low at cycle %0d, want %0d", tag, dt_fall, RD_WAIT + 1); end
      n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL %s_data: CPU_DOUT %h, want %h", tag, got, exp_v); end
      release_bus(tag);
   endtask

   task automatic bank_write(input logic [7:0] d, input string tag);
      int dt_fall;
      logic bank_at;
      @(negedge clk);
      bank_sel = 1'b1; rnw = 1'b0; din = d; lds_n = 1'b0;
      dt_fall = -1; bank_at = 1'bx;
      for (int j = 0; j < 10 && dt_fall < 0; j++) begin
         @(negedge clk);
         if (!cpu_dtack_n) begin dt_fall = j; bank_at = oki_bank; end
      end
      bank_m = d[0];
      n_cmp++; if (dt_fall != 1) begin n_err++; $display("FAIL %s_dtack: DTACK low at cycle %0d, want 1", tag, dt_fall); end
      n_cmp++; if (bank_at !== bank_m) begin n_err++; $display("FAIL %s_bank: OKI_BANK %b, want %b", tag, bank_at, bank_m); end
      release_bus(tag);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ym_cen = 1'b0; oki_cen = 1'b0; ym_dout = 8'h00; oki_dout = 8'h00;
      bus_idle();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (cpu_dout !== 8'h00)   begin n_err++; $display("FAIL reset_dout: %h want 00", cpu_dout); end
      n_cmp++; if (cpu_dtack_n !== 1'b1) begin n_err++; $display("FAIL reset_dtack: %b want 1", cpu_dtack_n); end
      n_cmp++; if (ym_cs !== 1'b0)       begin n_err++; $display("FAIL reset_ym_cs: %b want 0", ym_cs); end
      n_cmp++; if (ym_we !== 1'b1)       begin n_err++; $display("FAIL reset_ym_we: %b want 1", ym_we); end
      n_cmp++; if (ym_wr_cmd !== 1'b0)   begin n_err++; $display("FAIL reset_wr_cmd: %b want 0", ym_wr_cmd); end
      n_cmp++; if (ym_din !== 8'h00)     begin n_err++; $display("FAIL reset_ym_din: %h want 00", ym_din); end
      n_cmp++; if (oki_we !== 1'b1)      begin n_err++; $display("FAIL reset_oki_we: %b want 1", oki_we); end
      n_cmp++; if (oki_din !== 8'h00)    begin n_err++; $display("FAIL reset_oki_din: %h want 00", oki_din); end
      n_cmp++; if (oki_bank !== 1'b0)    begin n_err++; $display("FAIL reset_bank: %b want 0", oki_bank); end
      bank_m = 1'b0;
   endtask

   task automatic test_ym_write();
      write_txn(1'b0, 1'b0, 8'h28, 4, 0, -1, "ym_reg28");
      for (int i = 0; i < 3; i++) begin
         int p;
         p = $urandom_range(1, 8);
         write_txn(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), p, $urandom_range(0, p - 1), -1, "ym_rand");
      end
   endtask

   task automatic test_oki_write();
      write_txn(1'b1, 1'b0, 8'h80, 8, 0, -1, "oki_80");
      for (int i = 0; i < 3; i++) begin
         int p;
         p = $urandom_range(1, 8);
         write_txn(1'b1, 1'b0, 8'($urandom), p, $urandom_range(0, p - 1), -1, "oki_rand");
      end
   endtask

   task automatic test_bank();
      bank_write(8'h01, "bank_w1");
      read_txn(2, 8'h5a, "bank_rd1");
      bank_write(8'h00, "bank_w0");
      read_txn(2, 8'ha5, "bank_rd0");
   endtask

   task automatic test_read();
      read_txn(0, 8'h80, "ym_rd80");
      read_txn(0, 8'($urandom), "ym_rd_rand");
      read_txn(1, 8'($urandom), "oki_rd_rand");
   endtask

   // Sound paused: only the timeout can release the YM strobe
   task automatic test_pause();
      int we_fall, we_rise, dt_fall;
      ym_cen = 1'b0; oki_cen = 1'b0;
      @(negedge clk);
      ym_sel = 1'b1; rnw = 1'b0; din = 8'h3c; lds_n = 1'b0;
      we_fall = -1; we_rise = -1; dt_fall = -1;
      for (int j = 0; j < TIMEOUT + 100 && dt_fall < 0; j++) begin
         @(negedge clk);
         if (!ym_we && we_fall < 0) we_fall = j;
         if (ym_we && we_fall >= 0 && we_rise < 0) we_rise = j;
         if (!cpu_dtack_n && dt_fall < 0) dt_fall = j;
      end
      n_cmp++; if (we_fall != 1) begin n_err++; $display("FAIL pause_we_fall: %0d want 1", we_fall); end
      n_cmp++; if (dt_fall < TIMEOUT - 8 || dt_fall > TIMEOUT + 8) begin n_err++; $display("FAIL pause_timeout: DTACK at %0d, want near %0d", dt_fall, TIMEOUT); end
      n_cmp++; if (we_rise != dt_fall - 1) begin n_err++; $display("FAIL pause_release: WE high at %0d, want %0d", we_rise, dt_fall - 1); end
      release_bus("pause");
   endtask

   task automatic test_abort();
      write_txn(1'b0, 1'b1, 8'hc3, 6, 3, 2, "ym_abort");
      write_txn(1'b1, 1'b0, 8'h11, 5, 4, 1, "oki_abort");
      write_txn(1'b0, 1'b0, 8'h22, 3, 0, -1, "after_abort");
   endtask

   task automatic test_bad_select();
      for (int v = 0; v < 3; v++) begin
         bit we_low, cs_hi, dt_low;
         @(negedge clk);
         ym_sel = (v != 2); oki_sel = (v == 0); bank_sel = (v == 1);
         rnw = 1'b0; din = 8'hff; lds_n = 1'b0;
         if (v == 2) begin ym_sel = 1'b0; rnw = 1'b1; end
         we_low = 1'b0; cs_hi = 1'b0; dt_low = 1'b0;
         for (int j = 0; j < 12; j++) begin
            ym_cen = 1'b1; oki_cen = 1'b1;
            @(negedge clk);
            if (!ym_we || !oki_we) we_low = 1'b1;
            if (ym_cs) cs_hi = 1'b1;
            if (!cpu_dtack_n) dt_low = 1'b1;
         end
         n_cmp++; if (we_low !== 1'b0) begin n_err++; $display("FAIL badsel%0d_strobe: strobe went low", v); end
         n_cmp++; if (cs_hi !== 1'b0)  begin n_err++; $display("FAIL badsel%0d_cs: CS went high", v); end
         n_cmp++; if (dt_low !== 1'b0) begin n_err++; $display("FAIL badsel%0d_dtack: DTACK went low", v); end
         release_bus("badsel");
      end
   endtask

   task automatic test_reset_mid();
      bank_write(8'h01, "pre_rst_bank");
      ym_cen = 1'b0; oki_cen = 1'b0;
      @(negedge clk);
      ym_sel = 1'b1; rnw = 1'b0; din = 8'h77; lds_n = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++; if (ym_we !== 1'b0) begin n_err++; $display("FAIL rstmid_pre: WE %b before reset, want 0", ym_we); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (ym_we !== 1'b1)       begin n_err++; $display("FAIL rstmid_we: %b want 1", ym_we); end
      n_cmp++; if (ym_cs !== 1'b0)       begin n_err++; $display("FAIL rstmid_cs: %b want 0", ym_cs); end
      n_cmp++; if (cpu_dtack_n !== 1'b1) begin n_err++; $display("FAIL rstmid_dtack: %b want 1", cpu_dtack_n); end
      n_cmp++; if (oki_bank !== 1'b0)    begin n_err++; $display("FAIL rstmid_bank: %b want 0", oki_bank); end
      n_cmp++; if (ym_din !== 8'h00)     begin n_err++; $display("FAIL rstmid_din: %h want 00", ym_din); end
      bank_m = 1'b0;
      bus_idle();
      @(negedge clk);
      rst_n = 1'b1;
      write_txn(1'b0, 1'b1, 8'h9e, 4, 1, -1, "post_rst");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         int kind, p;
         kind = $urandom_range(0, 5);
         p = $urandom_range(1, 8);
         case (kind)
            0: write_txn(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), p, $urandom_range(0, p - 1), -1, "b2b_ym");
            1: write_txn(1'b1, 1'b0, 8'($urandom), p, $urandom_range(0, p - 1), -1, "b2b_oki");
            2: bank_write(8'($urandom), "b2b_bank");
            3: read_txn(0, 8'($urandom), "b2b_ym_rd");
            4: read_txn(1, 8'($urandom), "b2b_oki_rd");
            default: read_txn(2, 8'($urandom), "b2b_bank_rd");
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_ym_write();
      test_oki_write();
      test_bank();
      test_read();
      test_pause();
      test_abort();
      test_bad_select();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
